axis_extremum_finder: RTL and testbench

//   Streaming min/max detector on a signed AXI4-Stream sample input (slave side only).

---
 rtl/axis_extremum_finder_if.sv | 15 +
 rtl/axis_extremum_finder.sv | 90 +++++++++
 tb/tb_axis_extremum_finder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_extremum_finder_if.sv
// Purpose: sample stream bundle (tdata/tvalid/tready) between a producer and the extremum finder.
// Latency: none, wires only.
// Backpressure: carried by tready; the finder side drives it constantly high.
// Ports: tdata (TDATA_WIDTH, signed two's-complement sample), tvalid, tready.
//   master modport drives tdata/tvalid, slave modport drives tready.
interface axis_extremum_finder_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_extremum_finder.sv
// Purpose: streaming min/max over non-overlapping windows of 2^EF_log_count accepted samples,
//   results presented with a sign-extending right shift.
// Latency: results and EF_valid pulse appear one cycle after the window's final beat.
// Backpressure: none, tready is tied high; tvalid=0 cycles leave all state untouched.
// Ports:
//   aclk, areset          clock and synchronous active-high reset
//   EF_log_count [4:0]    log2 of window length, 0 disables the finder
//   EF_shift [2:0]        arithmetic right shift applied to results at window end
//   s_axis (slave)        signed sample stream
//   EF_maximum/minimum    shifted max/min of the last completed window
//   EF_valid              one-cycle pulse when the results update
module axis_extremum_finder #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [4:0]                         EF_log_count,
  input  logic [2:0]                         EF_shift,
  axis_extremum_finder_if.slave              s_axis,
  output logic signed [AXIS_TDATA_WIDTH-1:0] EF_maximum,
  output logic signed [AXIS_TDATA_WIDTH-1:0] EF_minimum,
  output logic                               EF_valid
);

  logic        [4:0]                  log_count_q;
  logic        [31:0]                 count;
  logic        [31:0]                 last_idx;
  logic signed [AXIS_TDATA_WIDTH-1:0] sample;
  logic signed [AXIS_TDATA_WIDTH-1:0] run_max;
  logic signed [AXIS_TDATA_WIDTH-1:0] run_min;
  logic signed [AXIS_TDATA_WIDTH-1:0] next_max;
  logic signed [AXIS_TDATA_WIDTH-1:0] next_min;

  assign s_axis.tready = 1'b1;
  assign sample        = s_axis.tdata;

  // Index of the final beat of the window; log_count==31 still fits in 32 bits.
  assign last_idx = (32'd1 << EF_log_count) - 32'd1;

  // Running extrema including the current beat; the first beat of a window seeds both.
  always_comb begin
    next_max = run_max;
    next_min = run_min;
    if (count == 32'd0) begin
      next_max = sample;
      next_min = sample;
    end else begin
      if (sample > run_max) next_max = sample;
      if (sample < run_min) next_min = sample;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      log_count_q <= 5'd0;
      count       <= 32'd0;
      run_max     <= '0;
      run_min     <= '0;
      EF_maximum  <= '0;
      EF_minimum  <= '0;
      EF_valid    <= 1'b0;
    end else begin
      EF_valid    <= 1'b0;
      log_count_q <= EF_log_count;
      if (EF_log_count != log_count_q) begin
        // Window length changed: restart, and let a valid beat on this edge open the new window.
        count <= 32'd0;
        if (EF_log_count != 5'd0 && s_axis.tvalid) begin
          run_max <= sample;
          run_min <= sample;
          count   <= 32'd1;
        end
      end else if (EF_log_count == 5'd0) begin
        count <= 32'd0;
      end else if (s_axis.tvalid) begin
        run_max <= next_max;
        run_min <= next_min;
        if (count == last_idx) begin
          EF_maximum <= next_max >>> EF_shift;
          EF_minimum <= next_min >>> EF_shift;
          EF_valid   <= 1'b1;
          count      <= 32'd0;
        end else begin
          count <= count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_extremum_finder.sv
// Purpose: directed self-checking bench for axis_extremum_finder.
// Ports: none; drives the DUT through an axis_extremum_finder_if instance.
module tb_axis_extremum_finder;
  logic              aclk = 1'b0;
  logic              areset;
  logic [4:0]        log_count;
  logic [2:0]        shift;
  logic signed [31:0] ef_max;
  logic signed [31:0] ef_min;
  logic              ef_valid;
  int                checks = 0;
  int                failures = 0;

  axis_extremum_finder_if #(.TDATA_WIDTH(32)) s_axis ();

  axis_extremum_finder #(.AXIS_TDATA_WIDTH(32)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .EF_log_count (log_count),
    .EF_shift     (shift),
    .s_axis       (s_axis),
    .EF_maximum   (ef_max),
    .EF_minimum   (ef_min),
    .EF_valid     (ef_valid)
  );

  always #5 aclk = ~aclk;

  // Present one cycle of stream input, return just after the edge that consumes it.
  task automatic beat(input logic signed [31:0] d, input logic v);
    @(negedge aclk);
    s_axis.tdata  = d;
    s_axis.tvalid = v;
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    areset        = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_reset();
    log_count = 5'd0;
    shift     = 3'd0;
    apply_reset();
    #1;
    checks++; if (ef_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ef_valid); end
    checks++; if (ef_max !== 32'sd0) begin failures++; $display("FAIL reset_max got=%0d exp=0", ef_max); end
    checks++; if (ef_min !== 32'sd0) begin failures++; $display("FAIL reset_min got=%0d exp=0", ef_min); end
    checks++; if (s_axis.tready !== 1'b1) begin failures++; $display("FAIL tready got=%0b exp=1", s_axis.tready); end
  endtask

  task automatic test_disabled();
    int v[5] = '{-20, -10, 10, 20, 10};
    for (int i = 0; i < 5; i++) begin
      beat(v[i], 1'b1);
      checks++; if (ef_valid !== 1'b0) begin failures++; $display("FAIL disabled_valid beat=%0d got=%0b exp=0", i, ef_valid); end
    end
    checks++; if (ef_max !== 32'sd0 || ef_min !== 32'sd0) begin
      failures++; $display("FAIL disabled_hold max=%0d min=%0d exp=0/0", ef_max, ef_min);
    end
  endtask

  task automatic test_window();
    int v[8] = '{-10, -30, -40, -20, 10, 20, 30, 40};
    log_count = 5'd3;  // changes on the -10 beat, which opens the window
    for (int i = 0; i < 8; i++) begin
      beat(v[i], 1'b1);
      checks++; if (ef_valid !== (i == 7)) begin failures++; $display("FAIL window_valid beat=%0d got=%0b exp=%0b", i, ef_valid, (i == 7)); end
    end
    checks++; if (ef_max !== 32'sd40) begin failures++; $display("FAIL window_max got=%0d exp=40", ef_max); end
    checks++; if (ef_min !== -32'sd40) begin failures++; $display("FAIL window_min got=%0d exp=-40", ef_min); end
  endtask

  task automatic test_partial();
    int v[4] = '{50, 60, 50, 40};
    for (int i = 0; i < 4; i++) begin
      beat(v[i], 1'b1);
      checks++; if (ef_valid !== 1'b0) begin failures++; $display("FAIL partial_valid beat=%0d got=%0b exp=0", i, ef_valid); end
    end
    checks++; if (ef_max !== 32'sd40 || ef_min !== -32'sd40) begin
      failures++; $display("FAIL partial_hold max=%0d min=%0d exp=40/-40", ef_max, ef_min);
    end
  endtask

  task automatic test_shift();
    int v[8] = '{-10, -30, -40, -20, 10, 20, 30, 40};
    int w[8] = '{-10, -30, -41, -20, 10, 20, 30, 40};
    apply_reset();  // discards the partial window left by the previous test
    #1;
    checks++; if (ef_max !== 32'sd0 || ef_min !== 32'sd0) begin
      failures++; $display("FAIL reset_mid_window max=%0d min=%0d exp=0/0", ef_max, ef_min);
    end
    // Shift only matters at the window-end edge.
    shift = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) shift = 3'd1;
      beat(v[i], 1'b1);
      checks++; if (ef_valid !== (i == 7)) begin failures++; $display("FAIL shift1_valid beat=%0d got=%0b exp=%0b", i, ef_valid, (i == 7)); end
    end
    checks++; if (ef_max !== 32'sd20 || ef_min !== -32'sd20) begin
      failures++; $display("FAIL shift1_result max=%0d min=%0d exp=20/-20", ef_max, ef_min);
    end
    shift = 3'd3;
    for (int i = 0; i < 8; i++) beat(w[i], 1'b1);
    checks++; if (ef_valid !== 1'b1) begin failures++; $display("FAIL shift3_valid got=%0b exp=1", ef_valid); end
    checks++; if (ef_max !== 32'sd5 || ef_min !== -32'sd6) begin
      failures++; $display("FAIL shift3_result max=%0d min=%0d exp=5/-6", ef_max, ef_min);
    end
    beat(0, 1'b0);
    checks++; if (ef_valid !== 1'b0) begin failures++; $display("FAIL pulse_width got=%0b exp=0", ef_valid); end
  endtask

  task automatic test_gaps();
    int v[8] = '{100, -7, 3, -250, 0, 99, -1, 12};
    shift = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 1) begin
        beat(32'sd5000, 1'b0);  // ignored: tvalid low
        checks++; if (ef_valid !== 1'b0) begin failures++; $display("FAIL gap_valid idx=%0d got=%0b exp=0", i, ef_valid); end
      end
      beat(v[i], 1'b1);
      checks++; if (ef_valid !== (i == 7)) begin failures++; $display("FAIL gaps_valid beat=%0d got=%0b exp=%0b", i, ef_valid, (i == 7)); end
    end
    checks++; if (ef_max !== 32'sd100 || ef_min !== -32'sd250) begin
      failures++; $display("FAIL gaps_result max=%0d min=%0d exp=100/-250", ef_max, ef_min);
    end
  endtask

  task automatic test_restart();
    int v[4] = '{9, -5, 4, 6};
    int r[4] = '{-8, 3, 17, -2};
    beat(1, 1'b1);
    beat(2, 1'b1);
    beat(3, 1'b1);
    log_count = 5'd2;  // the 9 beat opens the new 4-beat window
    for (int i = 0; i < 4; i++) begin
      beat(v[i], 1'b1);
      checks++; if (ef_valid !== (i == 3)) begin failures++; $display("FAIL logchg_valid beat=%0d got=%0b exp=%0b", i, ef_valid, (i == 3)); end
    end
    checks++; if (ef_max !== 32'sd9 || ef_min !== -32'sd5) begin
      failures++; $display("FAIL logchg_result max=%0d min=%0d exp=9/-5", ef_max, ef_min);
    end
    beat(500, 1'b1);
    beat(-500, 1'b1);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      beat(r[i], 1'b1);
      checks++; if (ef_valid !== (i == 3)) begin failures++; $display("FAIL rst_restart_valid beat=%0d got=%0b exp=%0b", i, ef_valid, (i == 3)); end
    end
    checks++; if (ef_max !== 32'sd17 || ef_min !== -32'sd8) begin
      failures++; $display("FAIL rst_restart_result max=%0d min=%0d exp=17/-8", ef_max, ef_min);
    end
  endtask

  task automatic test_full_scale();
    log_count = 5'd1;
    shift     = 3'd0;
    beat(32'sh7FFF_FFFF, 1'b1);
    beat(32'sh8000_0000, 1'b1);
    checks++; if (ef_valid !== 1'b1 || ef_max !== 32'sh7FFF_FFFF || ef_min !== 32'sh8000_0000) begin
      failures++; $display("FAIL full_scale valid=%0b max=%0d min=%0d exp=1/2147483647/-2147483648", ef_valid, ef_max, ef_min);
    end
    shift = 3'd7;
    beat(32'sh8000_0000, 1'b1);
    beat(32'sh7FFF_FFFF, 1'b1);
    checks++; if (ef_max !== 32'sd16777215 || ef_min !== -32'sd16777216) begin
      failures++; $display("FAIL full_scale_shift7 max=%0d min=%0d exp=16777215/-16777216", ef_max, ef_min);
    end
    shift = 3'd0;
    beat(3, 1'b1);
    beat(3, 1'b1);
    checks++; if (ef_valid !== 1'b1 || ef_max !== 32'sd3 || ef_min !== 32'sd3) begin
      failures++; $display("FAIL equal_samples valid=%0b max=%0d min=%0d exp=1/3/3", ef_valid, ef_max, ef_min);
    end
    // Disabling mid-window: nothing updates, results hold.
    beat(-90, 1'b1);
    log_count = 5'd0;
    for (int i = 0; i < 4; i++) begin
      beat(1000 * (i + 1), 1'b1);
      checks++; if (ef_valid !== 1'b0) begin failures++; $display("FAIL disable_valid beat=%0d got=%0b exp=0", i, ef_valid); end
    end
    checks++; if (ef_max !== 32'sd3 || ef_min !== 32'sd3) begin
      failures++; $display("FAIL disable_hold max=%0d min=%0d exp=3/3", ef_max, ef_min);
    end
  endtask

  initial begin
    areset        = 1'b1;
    log_count     = 5'd0;
    shift         = 3'd0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    test_reset();
    test_disabled();
    test_window();
    test_partial();
    test_shift();
    test_gaps();
    test_restart();
    test_full_scale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
